vmask_gen: RTL and testbench
============================

Name: vmask_gen

Overview:
- Mask-word generator; the write-side counterpart of the popcount block. That block reads mask words and reduces them to a scalar count; this block takes a scalar count and expands it into a stream of mask words.
- Emits `in_words` consecutive words with word addresses. The first `in_count` bits, LSB-first across words, are 1 and all remaining bits are 0.
- Used by the vALU to build body/tail masks (vl-style thermometer masks) and to write them back through the same address/valid path the other vALU units use.

Parameters:
- REQ_DATA_WIDTH, 64: mask bits per output word (W); power of two, ≥8.
- REQ_ADDR_WIDTH, 32: width of word address.
- COUNT_WIDTH, 16: width of `in_count` and the internal remaining-bits counter.
- WORDS_WIDTH, 8: width of `in_words`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_count  in  COUNT_WIDTH  number of leading 1 bits.
- in_words  in  WORDS_WIDTH  number of words to emit.
- in_addr  in  REQ_ADDR_WIDTH  word address of first output word.
- out_vec  out  REQ_DATA_WIDTH  generated mask word.
- out_addr  out  REQ_ADDR_WIDTH  word address of `out_vec`.
- out_valid  out  1  `out_vec`/`out_addr`/`out_end` valid.
- out_ready  in  1  consumer accepts current word.
- out_end  out  1  current word is last of request.

Behaviour:
- Reset (rst=0, async): state=IDLE, out_vec=0, out_addr=0, out_valid=0, out_end=0, internal counters=0. `in_ready` is 1 one cycle after rst deasserts; it is 0 while rst=0.
- FSM has two states, IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - Request accepted when in_valid & in_ready.
  - If in_words==0: request is consumed, nothing is emitted, and the FSM stays in IDLE.
  - Otherwise: latch rem=in_count, left=in_words, addr=in_addr, then go to EMIT.
- EMIT:
  - in_ready=0; new in_valid is ignored (not queued).
  - All outputs are registered.
  - The first word is presented with out_valid=1 on the cycle after acceptance (latency 1).
- Word content: bit i = 1 iff i < rem.
  - rem ≥ W → all ones.
  - rem == 0 → all zeros.
  - Otherwise → (1<<rem)-1.
- On handshake (out_valid & out_ready):
  - rem = (rem > W) ? rem-W : 0 (saturating; never wraps).
  - left = left-1.
  - out_addr = out_addr+1, wrapping modulo 2^REQ_ADDR_WIDTH.
  - The next word is presented in the following cycle, so with out_ready held at 1 the block streams one word per cycle.
- out_end=1 exactly on the word where left==1.
- Handshake on the out_end word → out_valid=0 and state=IDLE next cycle; in_ready=1 in that same cycle. This gives a minimum 1-cycle bubble between requests.
- Backpressure: while out_valid & !out_ready, out_vec, out_addr and out_end are held stable, and rem/left do not change.
- in_count > in_words*W: the excess is silently dropped; all emitted words are all-ones.
- Async reset mid-EMIT: outputs clear immediately and the request is abandoned; no partial completion is reported.
- X on in_count/in_words/in_addr when in_valid=0 must not propagate.

Optional Feature:
- Macro: VMASK_GEN_INVERT_EN.
- Defined:
  - Adds input port in_invert (1 bit), latched on acceptance.
  - When the latched value is 1, every emitted out_vec is bitwise complemented: the first in_count bits are 0 and the rest are 1.
  - Addresses, out_end, counting and handshakes are unchanged.
- Undefined: the port is absent, and behaviour is identical to in_invert=0.

Test Plan:
1. W=64; in_count=70, in_words=2, in_addr=0x10; out_ready=1 → cycle+1: out_vec=0xFFFF_FFFF_FFFF_FFFF, addr 0x10, end=0. Cycle+2: out_vec=0x3F, addr 0x11, end=1. Cycle+3: out_valid=0, in_ready=1.
2. in_count=0, in_words=3, in_addr=0 → three words of 0x0 at addr 0,1,2; out_end only on addr 2.
3. in_count=200, in_words=2 → two all-ones words (saturation); then idle.
4. in_count=5, in_words=1; out_ready=0 for 3 cycles after out_valid rises → out_vec=0x1F, addr and end=1 held stable for 4 cycles; single transfer counted when out_ready=1.
5. rst=0 during EMIT, after 1 of 4 words transferred → out_valid=0 and out_vec=0 immediately. After rst=1: in_ready=1, and no further words are emitted.
6. in_words=0 with in_valid=1 → no out_valid pulse ever; in_ready stays 1. A following request (in_count=1, in_words=1) yields out_vec=0x1, end=1. With VMASK_GEN_INVERT_EN and in_invert=1, the same request yields out_vec=0xFFFF_FFFF_FFFF_FFFE.

Source files
------------

// File: rtl/vmask_gen_if.sv
// Request/word-stream bundle for vmask_gen: request side in_*, mask word stream out_*.
// in_invert exists only when VMASK_GEN_INVERT_EN is defined.
interface vmask_gen_if #(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int WORDS_WIDTH    = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [COUNT_WIDTH-1:0]    in_count;
  logic [WORDS_WIDTH-1:0]    in_words;
  logic [REQ_ADDR_WIDTH-1:0] in_addr;
`ifdef VMASK_GEN_INVERT_EN
  logic                      in_invert;
`endif
  logic [REQ_DATA_WIDTH-1:0] out_vec;
  logic [REQ_ADDR_WIDTH-1:0] out_addr;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_end;

  modport slave (
    input  in_valid, in_count, in_words, in_addr,
`ifdef VMASK_GEN_INVERT_EN
    input  in_invert,
`endif
    input  out_ready,
    output in_ready, out_vec, out_addr, out_valid, out_end
  );

  modport master (
    output in_valid, in_count, in_words, in_addr,
`ifdef VMASK_GEN_INVERT_EN
    output in_invert,
`endif
    output out_ready,
    input  in_ready, out_vec, out_addr, out_valid, out_end
  );
endinterface

// File: rtl/vmask_gen.sv
// Expands a scalar bit count into a stream of LSB-first thermometer mask words.
// Optional VMASK_GEN_INVERT_EN adds in_invert, which complements every emitted word.
module vmask_gen #(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int WORDS_WIDTH    = 8
) (
  input logic        clk,
  input logic        rst,
  vmask_gen_if.slave bus
);
  localparam int W = REQ_DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] W_CNT = COUNT_WIDTH'(W);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                    state_q, state_d;
  logic                      rdy_q, rdy_d;
  logic [COUNT_WIDTH-1:0]    rem_q, rem_d;
  logic [WORDS_WIDTH-1:0]    left_q, left_d;
  logic [REQ_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [W-1:0]              vec_q, vec_d;
  logic                      valid_q, valid_d;
  logic                      end_q, end_d;
  logic                      inv_q, inv_d;
  logic                      inv_in, accept, xfer;

`ifdef VMASK_GEN_INVERT_EN
  assign inv_in = bus.in_invert;
`else
  assign inv_in = 1'b0;
`endif

  // rdy_q is only high in IDLE, so accept never fires while a request is being emitted.
  assign accept = bus.in_valid & rdy_q;
  assign xfer   = valid_q & bus.out_ready;

  function automatic logic [W-1:0] mask_of(input logic [COUNT_WIDTH-1:0] rem, input logic inv);
    logic [W-1:0] m;
    if (rem >= W_CNT) m = '1;
    else              m = (W'(1) << rem) - W'(1);
    return m ^ {W{inv}};
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && bus.in_words != '0) state_d = EMIT;
      EMIT: if (xfer && end_q)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rem_d   = rem_q;
    left_d  = left_q;
    addr_d  = addr_q;
    vec_d   = vec_q;
    valid_d = valid_q;
    end_d   = end_q;
    inv_d   = inv_q;
    if (state_q == IDLE) begin
      if (accept && bus.in_words != '0) begin
        rem_d   = bus.in_count;
        left_d  = bus.in_words;
        addr_d  = bus.in_addr;
        inv_d   = inv_in;
        vec_d   = mask_of(bus.in_count, inv_in);
        valid_d = 1'b1;
        end_d   = (bus.in_words == WORDS_WIDTH'(1));
      end
    end else if (xfer) begin
      if (end_q) begin
        rem_d   = '0;
        left_d  = '0;
        vec_d   = '0;
        valid_d = 1'b0;
        end_d   = 1'b0;
      end else begin
        // Saturate at zero so an oversized count only ever yields all-ones words.
        rem_d  = (rem_q > W_CNT) ? rem_q - W_CNT : '0;
        left_d = left_q - WORDS_WIDTH'(1);
        addr_d = addr_q + REQ_ADDR_WIDTH'(1);
        vec_d  = mask_of(rem_d, inv_q);
        end_d  = (left_q == WORDS_WIDTH'(2));
      end
    end
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q   <= 1'b0;
      rem_q   <= '0;
      left_q  <= '0;
      addr_q  <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      rdy_q   <= rdy_d;
      rem_q   <= rem_d;
      left_q  <= left_d;
      addr_q  <= addr_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      inv_q   <= inv_d;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_vec   = vec_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_valid = valid_q;
  assign bus.out_end   = end_q;
endmodule

// File: tb/tb_vmask_gen.sv
// Self-checking bench for vmask_gen: directed cases plus random requests against a per-word model.
module tb_vmask_gen;
  localparam int W  = 64;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vmask_gen_if #(.REQ_DATA_WIDTH(W), .REQ_ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .WORDS_WIDTH(WW)) bus ();

  vmask_gen #(.REQ_DATA_WIDTH(W), .REQ_ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .WORDS_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word k covers absolute bits [k*W, k*W+W); a bit is set iff its absolute index < count.
  function automatic logic [63:0] exp_word(input int count, input int k, input bit inv);
    int bits = count - k * W;
    logic [63:0] w;
    if (bits >= W)      w = {64{1'b1}};
    else if (bits <= 0) w = 64'd0;
    else                w = {64{1'b1}} >> (W - bits);
    return inv ? ~w : w;
  endfunction

  task automatic set_invert(input bit inv);
`ifdef VMASK_GEN_INVERT_EN
    bus.in_invert = inv;
`else
    if (inv) begin end
`endif
  endtask

  function automatic bit eff_inv(input bit inv);
`ifdef VMASK_GEN_INVERT_EN
    return inv;
`else
    if (inv) return 1'b0;
    return 1'b0;
`endif
  endfunction

  task automatic scramble_req();
    bus.in_count = CW'($urandom);
    bus.in_words = WW'($urandom);
    bus.in_addr  = AW'($urandom);
    set_invert(1'($urandom));
  endtask

  // Issues one request and drains it; starts and ends on a falling edge.
  task automatic run_req(input int count, input int words, input logic [AW-1:0] addr,
                         input bit inv, input int ready_pct, input int stall);
    int budget;
    int k;
    int iter;
    bit r;
    logic [AW-1:0] ea;
    budget = 0;
    while (!bus.in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_count = CW'(count);
    bus.in_words = WW'(words);
    bus.in_addr  = addr;
    set_invert(inv);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_req();
    if (words == 0) begin
      repeat (3) begin
        check("zero_words_valid", 64'(bus.out_valid), 64'd0);
        check("zero_words_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
      end
      return;
    end
    check("first_valid", 64'(bus.out_valid), 64'd1);
    k = 0;
    iter = 0;
    while (k < words && iter < 2000) begin
      ea = addr + AW'(k);
      check("valid", 64'(bus.out_valid), 64'd1);
      check("busy_ready", 64'(bus.in_ready), 64'd0);
      check("vec", bus.out_vec, exp_word(count, k, eff_inv(inv)));
      check("addr", 64'(bus.out_addr), 64'(ea));
      check("end", 64'(bus.out_end), 64'(k == words - 1));
      r = (iter >= stall) && ($urandom_range(99) < ready_pct);
      bus.out_ready = r;
      // Requests offered mid-stream must be ignored.
      bus.in_valid = 1'($urandom);
      @(negedge clk);
      iter++;
      if (r) k++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("words_done", 64'(k), 64'(words));
    check("done_valid", 64'(bus.out_valid), 64'd0);
    check("done_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int count;
    int words;
    logic [AW-1:0] addr;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble_req();
    set_invert(1'b0);

    #2;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_vec", bus.out_vec, 64'd0);
    check("rst_addr", 64'(bus.out_addr), 64'd0);
    check("rst_end", 64'(bus.out_end), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_release_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);

    run_req(70, 2, 32'h10, 1'b0, 100, 0);
    run_req(0, 3, 32'h0, 1'b0, 100, 0);
    run_req(200, 2, 32'h20, 1'b0, 100, 0);
    run_req(5, 1, 32'h40, 1'b0, 100, 3);
    run_req(7, 0, 32'h50, 1'b0, 100, 0);
    run_req(1, 1, 32'h60, 1'b0, 100, 0);
    run_req(1, 1, 32'h61, 1'b1, 100, 0);
    run_req(128, 3, 32'hFFFF_FFFF, 1'b0, 100, 0);

    // Reset in the middle of a four-word request.
    bus.in_valid = 1'b1;
    bus.in_count = CW'(300);
    bus.in_words = WW'(4);
    bus.in_addr  = 32'h100;
    set_invert(1'b0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    check("mid_first_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("mid_second_addr", 64'(bus.out_addr), 64'h101);
    bus.out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_vec", bus.out_vec, 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_post_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (4) begin
      check("mid_no_emit", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;

    repeat (40) begin
      count = ($urandom_range(3) == 0) ? int'($urandom_range(65535)) : int'($urandom_range(450));
      words = int'($urandom_range(6));
      addr  = ($urandom_range(3) == 0) ? 32'hFFFF_FFFD : AW'($urandom);
      run_req(count, words, addr, 1'($urandom), int'($urandom_range(30, 100)),
              int'($urandom_range(2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
